// File: rtl/blackbox_adder_pkg.sv
// Shared definitions for the sum-offload responder.
//   - state_e      : server FSM states (IDLE / BUSY / DONE)
//   - WIDTH_DEF    : default operand width
//   - CHUNK_DEF    : default bits added per cycle
//   - N_DEF        : default number of chunks (WIDTH_DEF / CHUNK_DEF)
//   - KW_DEF       : default width of the chunk index
//   - k_width()    : chunk-index width for any chunk count (minimum 1 bit)
package blackbox_adder_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;
  localparam int N_DEF     = WIDTH_DEF / CHUNK_DEF;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int k_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KW_DEF = k_width(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/blackbox_adder_server_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit adder slice.
// Ports:
//   a, b  in  CHUNK  operand chunks
//   cin   in  1      carry in
//   sum   out CHUNK  chunk sum
//   cout  out 1      carry out
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Widen by one bit so the carry falls out of the top of the addition.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/blackbox_adder_server.sv
// blackbox_adder_server: responder for the sum-offload interface.
// Accepts two WIDTH-bit operands on a valid/ready request channel, adds them
// CHUNK bits per cycle through one shared adder slice, and returns the
// WIDTH+1-bit sum on a valid/ready response channel.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   io_req_valid/io_req_ready     request handshake
//   io_req_in1/io_req_in2         operands, sampled only on request fire
//   io_resp_valid/io_resp_ready   response handshake
//   io_resp_out                   {carry, sum}
//   io_busy                       high whenever not IDLE
//   io_done_count                 completed responses, wraps at 2^16
// Every output is a register or a decode of the state register.
module blackbox_adder_server
  import blackbox_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [WIDTH-1:0] io_req_in1,
  input  logic [WIDTH-1:0] io_req_in2,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [WIDTH:0]   io_resp_out,
  output logic             io_busy,
  output logic [15:0]      io_done_count
);

  localparam int             N      = WIDTH / CHUNK;
  localparam int             KW     = k_width(N);
  localparam logic [KW-1:0]  K_LAST = KW'(N - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             carry_q,  carry_d;
  logic [KW-1:0]    k_q,      k_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [15:0]      count_q,  count_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout;

  // Operand chunks are selected by the chunk index and fed to the one slice.
  assign a_chunk = a_q[int'(k_q) * CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(k_q) * CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_adder_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_comb begin
    // NOTE: every *_d starts as its hold value so no path leaves a signal
    // unassigned; otherwise synthesis would infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    k_d      = k_q;
    result_d = result_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io_req_valid) begin
          a_d      = io_req_in1;
          b_d      = io_req_in2;
          carry_d  = 1'b0;
          k_d      = '0;
          result_d = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        result_d[int'(k_q) * CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          result_d[WIDTH] = chunk_cout;
          k_d             = '0;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io_resp_ready) begin
          count_d = count_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign io_req_ready  = (state_q == ST_IDLE);
  assign io_resp_valid = (state_q == ST_DONE);
  assign io_busy       = (state_q != ST_IDLE);
  assign io_resp_out   = result_q;
  assign io_done_count = count_q;

endmodule

// File: tb/tb_blackbox_adder_server.sv
// Self-checking bench for blackbox_adder_server: directed corner cases plus
// randomized operands and response back-pressure, checked against plain
// arithmetic and a transaction counter kept in the bench.
module tb_blackbox_adder_server;
  import blackbox_adder_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int N = N_DEF;
  localparam int TIMEOUT = 4 * N + 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_req_valid;
  logic         io_req_ready;
  logic [W-1:0] io_req_in1;
  logic [W-1:0] io_req_in2;
  logic         io_resp_valid;
  logic         io_resp_ready;
  logic [W:0]   io_resp_out;
  logic         io_busy;
  logic [15:0]  io_done_count;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_count;

  blackbox_adder_server dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_in1    (io_req_in1),
    .io_req_in2    (io_req_in2),
    .io_resp_valid (io_resp_valid),
    .io_resp_ready (io_resp_ready),
    .io_resp_out   (io_resp_out),
    .io_busy       (io_busy),
    .io_done_count (io_done_count)
  );

  always #5 clock = ~clock;

  // Reference: unsigned sum, never truncated.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Presents one request from IDLE, then scrambles the operand bus and waits
  // for io_resp_valid. lat = edges after the accepting edge until valid is seen.
  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    io_req_valid = 1'b1;
    io_req_in1   = a;
    io_req_in2   = b;
    @(posedge clock); #1;
    io_req_valid = 1'b0;
    io_req_in1   = $urandom;
    io_req_in2   = $urandom;
    lat = 0;
    while (!io_resp_valid && lat < TIMEOUT) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // Completes the response handshake on the next edge.
  task automatic finish_resp();
    io_resp_ready = 1'b1;
    @(posedge clock); #1;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    io_req_valid  = 1'b1;   // must not be accepted while in reset
    io_req_in1    = 32'hDEADBEEF;
    io_req_in2    = 32'h12345678;
    io_resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset        = 1'b0;
    io_req_valid = 1'b0;
    exp_count    = 16'd0;
    @(posedge clock); #1;
    tests_run++;
    if (io_req_ready !== 1'b1 || io_resp_valid !== 1'b0 || io_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: ready=%b valid=%b busy=%b, required 1 0 0",
               io_req_ready, io_resp_valid, io_busy);
    end
    tests_run++;
    if (io_resp_out !== '0 || io_done_count !== exp_count) begin
      tests_failed++;
      $display("FAIL reset_values: out=%h count=%0d, required 0 0", io_resp_out, io_done_count);
    end
  endtask

  task automatic test_basic();
    int lat;
    io_resp_ready = 1'b1;
    send_req(32'h5, 32'h3, lat);
    tests_run++;
    if (lat !== N) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, N);
    end
    tests_run++;
    if (io_resp_out !== 33'h0_0000_0008) begin
      tests_failed++;
      $display("FAIL basic_sum: got %h, required 000000008", io_resp_out);
    end
    finish_resp();
    tests_run++;
    if (io_done_count !== 16'd1 || io_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_after: count=%0d ready=%b, required 1 1", io_done_count, io_req_ready);
    end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00FF_00FF};
    logic [W-1:0] vb [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0001_0001};
    logic [W:0]   ve [3] = '{33'h1_0000_0000, 33'h1_FFFF_FFFE, 33'h0_0100_0100};
    int lat;
    io_resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_req(va[i], vb[i], lat);
      tests_run++;
      if (io_resp_out !== ve[i] || lat !== N) begin
        tests_failed++;
        $display("FAIL carry_chain[%0d]: got %h lat %0d, required %h lat %0d",
                 i, io_resp_out, lat, ve[i], N);
      end
      finish_resp();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int lat;
    io_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      send_req(a, b, lat);
      tests_run++;
      if (io_resp_out !== ref_sum(a, b) || lat !== N) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got %h lat %0d, required %h lat %0d",
                 i, io_resp_out, lat, ref_sum(a, b), N);
      end
      finish_resp();
      // The next request can go out immediately: N+2 cycles per transaction.
      tests_run++;
      if (io_req_ready !== 1'b1 || io_done_count !== exp_count) begin
        tests_failed++;
        $display("FAIL back_to_back_ready[%0d]: ready=%b count=%0d, required 1 %0d",
                 i, io_req_ready, io_done_count, exp_count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    int lat;
    a = $urandom;
    b = $urandom;
    exp = ref_sum(a, b);
    io_resp_ready = 1'b0;
    send_req(a, b, lat);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (io_resp_valid !== 1'b1 || io_resp_out !== exp || io_req_ready !== 1'b0 || io_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL backpressure[%0d]: valid=%b out=%h ready=%b busy=%b, required 1 %h 0 1",
                 i, io_resp_valid, io_resp_out, io_req_ready, io_busy, exp);
      end
      io_req_valid = 1'($urandom);
      io_req_in1   = $urandom;
      io_req_in2   = $urandom;
      @(posedge clock); #1;
    end
    io_req_valid = 1'b0;
    finish_resp();
    tests_run++;
    if (io_busy !== 1'b0 || io_req_ready !== 1'b1 || io_done_count !== exp_count) begin
      tests_failed++;
      $display("FAIL backpressure_release: busy=%b ready=%b count=%0d, required 0 1 %0d",
               io_busy, io_req_ready, io_done_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen_valid;
    io_resp_ready = 1'b1;
    io_req_valid  = 1'b1;
    io_req_in1    = $urandom;
    io_req_in2    = $urandom;
    @(posedge clock); #1;          // accepted; now BUSY cycle 1
    io_req_valid = 1'b0;
    @(posedge clock); #1;          // BUSY cycle 2
    reset = 1'b1;
    @(posedge clock); #1;
    reset     = 1'b0;
    exp_count = 16'd0;
    tests_run++;
    if (io_busy !== 1'b0 || io_req_ready !== 1'b1 || io_resp_out !== '0 || io_done_count !== exp_count) begin
      tests_failed++;
      $display("FAIL reset_mid_state: busy=%b ready=%b out=%h count=%0d, required 0 1 0 0",
               io_busy, io_req_ready, io_resp_out, io_done_count);
    end
    seen_valid = 1'b0;
    repeat (2 * N) begin
      if (io_resp_valid) seen_valid = 1'b1;
      @(posedge clock); #1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_resp: response seen=%b, required 0", seen_valid);
    end
    send_req(32'h10, 32'h20, lat);
    tests_run++;
    if (io_resp_out !== 33'h0_0000_0030 || lat !== N) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: got %h lat %0d, required 000000030 lat %0d",
               io_resp_out, lat, N);
    end
    finish_resp();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int lat, delay;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      delay = $urandom_range(0, 3);
      io_resp_ready = (delay == 0);
      send_req(a, b, lat);
      tests_run++;
      if (io_resp_out !== ref_sum(a, b) || lat !== N) begin
        tests_failed++;
        $display("FAIL random[%0d]: %h+%h got %h lat %0d, required %h lat %0d",
                 i, a, b, io_resp_out, lat, ref_sum(a, b), N);
      end
      repeat (delay) begin
        @(posedge clock); #1;
      end
      tests_run++;
      if (io_resp_valid !== 1'b1 || io_resp_out !== ref_sum(a, b)) begin
        tests_failed++;
        $display("FAIL random_hold[%0d]: valid=%b out=%h, required 1 %h",
                 i, io_resp_valid, io_resp_out, ref_sum(a, b));
      end
      finish_resp();
      tests_run++;
      if (io_done_count !== exp_count) begin
        tests_failed++;
        $display("FAIL random_count[%0d]: got %0d, required %0d", i, io_done_count, exp_count);
      end
    end
  endtask

  task automatic test_counter_wrap();
    int lat;
    force dut.count_q = 16'hFFFF;
    @(posedge clock); #1;
    release dut.count_q;
    exp_count = 16'hFFFF;
    @(posedge clock); #1;
    tests_run++;
    if (io_done_count !== exp_count) begin
      tests_failed++;
      $display("FAIL wrap_preload: got %h, required ffff", io_done_count);
    end
    io_resp_ready = 1'b1;
    send_req(32'h1, 32'h2, lat);
    finish_resp();
    tests_run++;
    if (io_done_count !== 16'h0000 || exp_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_count: got %h, required 0000", io_done_count);
    end
  endtask

  initial begin
    reset         = 1'b1;
    io_req_valid  = 1'b0;
    io_req_in1    = '0;
    io_req_in2    = '0;
    io_resp_ready = 1'b0;
    exp_count     = 16'd0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
